imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port 64x32 instruction memory between two requesters: the CPU fetch port (read-only) and a program loader port (read/write). The loader fills or patches program code at run time.
- Sits between the fetch stage and the instruction RAM.
- Arbitrates per cycle and tracks the one-cycle read latency. It also signals fetch stalls and guarantees fetch forward progress under loader traffic.

Parameters:
- ADDR_W, 6, word address width
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, consecutive denied fetch cycles after which fetch is forced to win (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  f_rdata valid (cycle after f_gnt)
- f_rdata  out  DATA_W  fetched instruction
- cpu_stall  out  1  f_req & ~f_gnt
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rvalid  out  1  l_rdata valid (cycle after a granted loader read)
- l_rdata  out  DATA_W  loader read-back data
- starve_cnt  out  4  current consecutive fetch-denial count (debug)

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs are 0.
  - starve_cnt = 0.
  - Pending-response register is cleared. A read granted in the cycle reset asserts produces no rvalid.
  - RAM contents are not cleared.
- Grants are combinational from the current-cycle request and registered state. At most one of f_gnt/l_gnt is high. A requester holds req/addr/data stable until granted.
- Priority:
  - Loader wins by default.
  - If starve_cnt == MAX_WAIT and f_req is high, fetch wins.
  - With only one request present, that request wins.
  - With no request, there is no grant and no RAM access.
- starve_cnt update:
  - Increment when f_req & l_gnt.
  - Clear when f_gnt or when f_req is low.
  - Saturates at MAX_WAIT.
- RAM access:
  - Port driven from the winner.
  - Write when l_gnt & l_we.
  - Read otherwise on grant.
  - Read data is registered: latency exactly 1 cycle.
- Response routing:
  - A 2-bit pending register {was_fetch, was_loader_read} is captured on grant.
  - The next cycle asserts f_rvalid or l_rvalid for exactly one cycle, with rdata from RAM.
  - Granted writes produce no rvalid.
  - rdata outputs hold their last value when rvalid is low.
- Back-to-back:
  - A new grant is allowed every cycle. Response N and grant N+1 overlap.
  - A write at cycle t followed by a read of the same address at t+1 returns the new data.
  - A read and write cannot share a cycle (single port), so there is no read-during-write case.
- Fetch stall: cpu_stall = f_req & ~f_gnt. The CPU holds PC while stalled.
- Worst-case fetch wait is MAX_WAIT cycles. The loader is never starved, because fetch wins only one cycle per window.
- Address wrap: DEPTH = 2**ADDR_W, so every address is valid and there is no wrap logic.

Decomposition:
- Package imem_pkg:
  - ADDR_W and DATA_W constants.
  - typedef imem_addr_t and imem_word_t.
  - enum owner_t {OWN_NONE, OWN_FETCH, OWN_LOAD} used for the grant/pending state.
- Sub-module imem_sync_ram:
  - Single-port, registered-read RAM, 2**ADDR_W x DATA_W.
  - Ports: clk, en, we, addr, wdata, rdata.
  - Optional $readmemh initialisation path parameter.

Test Plan:
- Reset with reset_n = 0 mid-read (f_req = 1, addr 5) -> f_rvalid stays 0 the next cycle; all outputs 0; after release, fetch of addr 5 returns the preloaded word at +1 cycle.
- Fetch-only stream at addr 0,1,2,3 every cycle -> f_gnt = 1 each cycle, f_rvalid at t+1 with words 0..3, cpu_stall = 0 throughout.
- Loader write addr 10 = 0xDEADBEEF, then a fetch of addr 10 the next cycle -> f_rdata = 0xDEADBEEF one cycle after its grant; no rvalid for the write.
- f_req and l_req both held high continuously, MAX_WAIT = 4 -> pattern of 4 l_gnt, then 1 f_gnt, repeating; starve_cnt reads 1,2,3,4,0; cpu_stall high on loader cycles.
- Loader read of addr 63 interleaved with a fetch of addr 0 on alternating cycles -> l_rvalid/f_rvalid each routed to the correct port with the correct data, never both high together.
- f_req dropped after 2 denials -> starve_cnt clears to 0; a later contention restarts the count from 1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
package imem_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned STARVE_W = 4;

    typedef logic [ADDR_W-1:0] imem_addr_t;
    typedef logic [DATA_W-1:0] imem_word_t;

    // Encoding doubles as the {was_fetch, was_loader_read} pending pair.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_LOAD  = 2'b01,
        OWN_FETCH = 2'b10
    } owner_t;

endpackage

// File: rtl/imem_sync_ram.sv
// Single-port instruction RAM with a registered read port (1-cycle latency).
module imem_sync_ram
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       en,
    input  logic       we,
    input  imem_addr_t addr,
    input  imem_word_t wdata,
    output imem_word_t rdata
);

    imem_word_t r_mem [DEPTH];
    imem_word_t r_rdata;

    // Array and read register are datapath only; no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter in front of the single-port instruction RAM, with
// loader-default priority, a starvation breaker for fetch and response routing.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                f_req,
    input  imem_addr_t          f_addr,
    output logic                f_gnt,
    output logic                f_rvalid,
    output imem_word_t          f_rdata,
    output logic                cpu_stall,
    input  logic                l_req,
    input  logic                l_we,
    input  imem_addr_t          l_addr,
    input  imem_word_t          l_wdata,
    output logic                l_gnt,
    output logic                l_rvalid,
    output imem_word_t          l_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic                w_force_fetch;
    logic                w_f_gnt;
    logic                w_l_gnt;
    logic                w_ram_en;
    logic                w_ram_we;
    imem_addr_t          w_ram_addr;
    imem_word_t          w_ram_rdata;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;
    owner_t              r_pend;
    owner_t              w_pend_nxt;
    imem_word_t          r_f_hold;
    imem_word_t          r_l_hold;

    // Asynchronous assert, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Per-cycle arbitration: loader by default, fetch once it has waited MAX_WAIT cycles.
    always_comb begin
        w_force_fetch = f_req && (r_starve == MAX_WAIT_C);
        w_l_gnt       = w_rst_n && l_req && !w_force_fetch;
        w_f_gnt       = w_rst_n && f_req && !w_l_gnt;
        w_ram_en      = w_f_gnt || w_l_gnt;
        w_ram_we      = w_l_gnt && l_we;
        w_ram_addr    = w_l_gnt ? l_addr : f_addr;
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (!f_req || w_f_gnt) begin
            w_starve_nxt = '0;
        end else if (w_l_gnt && (r_starve < MAX_WAIT_C)) begin
            w_starve_nxt = r_starve + STARVE_W'(1);
        end
    end

    always_comb begin
        w_pend_nxt = OWN_NONE;
        if (w_f_gnt) begin
            w_pend_nxt = OWN_FETCH;
        end else if (w_l_gnt && !l_we) begin
            w_pend_nxt = OWN_LOAD;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_starve <= '0;
            r_pend   <= OWN_NONE;
        end else begin
            r_starve <= w_starve_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    // Last delivered word per port, so rdata holds while rvalid is low.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_f_hold <= '0;
            r_l_hold <= '0;
        end else begin
            if (f_rvalid) begin
                r_f_hold <= w_ram_rdata;
            end
            if (l_rvalid) begin
                r_l_hold <= w_ram_rdata;
            end
        end
    end

    imem_sync_ram u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (l_wdata),
        .rdata (w_ram_rdata)
    );

    assign f_gnt      = w_f_gnt;
    assign l_gnt      = w_l_gnt;
    assign cpu_stall  = w_rst_n && f_req && !w_f_gnt;
    assign starve_cnt = r_starve;
    assign f_rvalid   = (r_pend == OWN_FETCH);
    assign l_rvalid   = (r_pend == OWN_LOAD);
    assign f_rdata    = f_rvalid ? w_ram_rdata : r_f_hold;
    assign l_rdata    = l_rvalid ? w_ram_rdata : r_l_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset, fetch streaming, RAW, contention and routing.
module tb_imem_arbiter;
    import imem_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                f_req;
    imem_addr_t          f_addr;
    logic                f_gnt;
    logic                f_rvalid;
    imem_word_t          f_rdata;
    logic                cpu_stall;
    logic                l_req;
    logic                l_we;
    imem_addr_t          l_addr;
    imem_word_t          l_wdata;
    logic                l_gnt;
    logic                l_rvalid;
    imem_word_t          l_rdata;
    logic [STARVE_W-1:0] starve_cnt;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .cpu_stall  (cpu_stall),
        .l_req      (l_req),
        .l_we       (l_we),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_rvalid   (l_rvalid),
        .l_rdata    (l_rdata),
        .starve_cnt (starve_cnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, then settle before checks.
    task automatic drive(input logic fr, input imem_addr_t fa, input logic lr,
                         input logic lwe, input imem_addr_t la, input imem_word_t lwd);
        @(negedge clk);
        f_req   = fr;
        f_addr  = fa;
        l_req   = lr;
        l_we    = lwe;
        l_addr  = la;
        l_wdata = lwd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic granted;
        reset_n = 1'b0;
        f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset state
        idle();
        idle();
        chk1("rst_f_gnt", f_gnt, 1'b0);
        chk1("rst_l_gnt", l_gnt, 1'b0);
        chk1("rst_f_rvalid", f_rvalid, 1'b0);
        chk32("rst_starve", 32'(starve_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        idle();
        idle();

        // Preload words 0..5 and 63 through the loader
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, 1'b1, ADDR_W'(k), 32'h1000_0000 + 32'(k));
            chk1("preload_l_gnt", l_gnt, 1'b1);
        end
        drive(1'b0, '0, 1'b1, 1'b1, 6'd63, 32'hCAFE_F00D);
        chk1("preload63_l_gnt", l_gnt, 1'b1);

        // Fetch of addr 5 granted in the cycle reset asserts
        drive(1'b1, 6'd5, 1'b0, 1'b0, '0, '0);
        chk1("midrd_f_gnt", f_gnt, 1'b1);
        chk1("write_no_l_rvalid", l_rvalid, 1'b0);
        reset_n = 1'b0;
        drive(1'b1, 6'd5, 1'b0, 1'b0, '0, '0);
        chk1("midrd_f_rvalid", f_rvalid, 1'b0);
        chk1("midrd_f_gnt_rst", f_gnt, 1'b0);
        chk1("midrd_stall_rst", cpu_stall, 1'b0);
        chk32("midrd_f_rdata_rst", f_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < 6 && !granted; i++) begin
            drive(1'b1, 6'd5, 1'b0, 1'b0, '0, '0);
            if (f_gnt) granted = 1'b1;
        end
        chk1("release_f_gnt_seen", granted, 1'b1);
        idle();
        chk1("release_f_rvalid", f_rvalid, 1'b1);
        chk32("release_f_rdata", f_rdata, 32'h1000_0005);

        // Fetch-only stream 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(i), 1'b0, 1'b0, '0, '0);
            chk1("stream_f_gnt", f_gnt, 1'b1);
            chk1("stream_stall", cpu_stall, 1'b0);
            if (i == 0) begin
                chk1("stream_rvalid0", f_rvalid, 1'b0);
            end else begin
                chk1("stream_rvalid", f_rvalid, 1'b1);
                chk32("stream_rdata", f_rdata, 32'h1000_0000 + 32'(i - 1));
            end
        end
        idle();
        chk1("stream_rvalid_last", f_rvalid, 1'b1);
        chk32("stream_rdata_last", f_rdata, 32'h1000_0003);
        idle();
        chk1("stream_rvalid_drop", f_rvalid, 1'b0);
        chk32("stream_rdata_hold", f_rdata, 32'h1000_0003);

        // Loader write then fetch of same address next cycle
        drive(1'b0, '0, 1'b1, 1'b1, 6'd10, 32'hDEAD_BEEF);
        chk1("raw_l_gnt", l_gnt, 1'b1);
        chk1("raw_f_gnt_idle", f_gnt, 1'b0);
        drive(1'b1, 6'd10, 1'b0, 1'b0, '0, '0);
        chk1("raw_f_gnt", f_gnt, 1'b1);
        chk1("raw_no_l_rvalid", l_rvalid, 1'b0);
        chk1("raw_no_f_rvalid", f_rvalid, 1'b0);
        idle();
        chk1("raw_f_rvalid", f_rvalid, 1'b1);
        chk32("raw_f_rdata", f_rdata, 32'hDEAD_BEEF);

        // Continuous contention: 4 loader grants then 1 fetch grant
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 6'd0, 1'b1, 1'b1, 6'd30, 32'h0000_0055);
            chk1("cont_f_gnt", f_gnt, (j % 5) == 4);
            chk1("cont_l_gnt", l_gnt, (j % 5) != 4);
            chk1("cont_stall", cpu_stall, (j % 5) != 4);
            chk32("cont_starve", 32'(starve_cnt), 32'(j % 5));
        end
        idle();
        chk32("cont_starve_end", 32'(starve_cnt), 32'd0);
        chk1("cont_f_rvalid", f_rvalid, 1'b1);
        chk32("cont_f_rdata", f_rdata, 32'h1000_0000);

        // Alternating loader read of 63 and fetch of 0
        drive(1'b0, '0, 1'b1, 1'b0, 6'd63, '0);
        chk1("alt_l_gnt", l_gnt, 1'b1);
        drive(1'b1, 6'd0, 1'b0, 1'b0, '0, '0);
        chk1("alt_f_gnt", f_gnt, 1'b1);
        chk1("alt_l_rvalid", l_rvalid, 1'b1);
        chk1("alt_f_rvalid_lo", f_rvalid, 1'b0);
        chk32("alt_l_rdata", l_rdata, 32'hCAFE_F00D);
        drive(1'b0, '0, 1'b1, 1'b0, 6'd63, '0);
        chk1("alt_f_rvalid", f_rvalid, 1'b1);
        chk1("alt_l_rvalid_lo", l_rvalid, 1'b0);
        chk32("alt_f_rdata", f_rdata, 32'h1000_0000);
        drive(1'b1, 6'd0, 1'b0, 1'b0, '0, '0);
        chk1("alt2_l_rvalid", l_rvalid, 1'b1);
        chk1("alt2_f_rvalid_lo", f_rvalid, 1'b0);
        chk32("alt2_l_rdata", l_rdata, 32'hCAFE_F00D);
        idle();
        chk1("alt3_f_rvalid", f_rvalid, 1'b1);
        chk1("alt3_l_rvalid_lo", l_rvalid, 1'b0);
        chk32("alt3_l_rdata_hold", l_rdata, 32'hCAFE_F00D);

        // Fetch request dropped after 2 denials clears the count
        drive(1'b1, 6'd1, 1'b1, 1'b1, 6'd30, 32'h0000_0055);
        chk32("drop_starve0", 32'(starve_cnt), 32'd0);
        drive(1'b1, 6'd1, 1'b1, 1'b1, 6'd30, 32'h0000_0055);
        chk32("drop_starve1", 32'(starve_cnt), 32'd1);
        drive(1'b0, 6'd1, 1'b1, 1'b1, 6'd30, 32'h0000_0055);
        chk32("drop_starve2", 32'(starve_cnt), 32'd2);
        chk1("drop_stall", cpu_stall, 1'b0);
        drive(1'b1, 6'd1, 1'b1, 1'b1, 6'd30, 32'h0000_0055);
        chk32("drop_cleared", 32'(starve_cnt), 32'd0);
        chk1("drop_l_gnt", l_gnt, 1'b1);
        idle();
        chk32("drop_restart", 32'(starve_cnt), 32'd1);
        idle();
        chk32("drop_idle_clear", 32'(starve_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
